// File: rtl/icache_assoc.sv
// Set-associative instruction cache with multi-word blocks, same-cycle hits and a sequential miss fill.
// Build option ICACHE_STATS_EN adds the hit_count/miss_count ports and their counters.
module icache_assoc #(
  parameter int unsigned SETS     = 8,
  parameter int unsigned WAYS     = 2,
  parameter int unsigned BLKWORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        iflush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned OB   = $clog2(BLKWORDS);
  localparam int unsigned IB   = $clog2(SETS);
  localparam int unsigned TAGW = 32 - 2 - OB - IB;
  localparam int unsigned OBW  = (OB > 0) ? OB : 1;
  localparam int unsigned WB   = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {IDLE, FILL} state_t;

  state_t          state_q;
  logic [OBW-1:0]  cnt_q;
  logic [TAGW-1:0] ftag_q;
  logic [IB-1:0]   fidx_q;
  logic [WAYS-1:0] valid_q [SETS];
  logic [WB-1:0]   ptr_q   [SETS];
  logic [TAGW-1:0] tag_q   [SETS][WAYS];
  logic [31:0]     data_q  [SETS][WAYS][BLKWORDS];
  logic [31:0]     fbuf_q  [BLKWORDS];

  logic [OBW-1:0]  off_c;
  logic [IB-1:0]   idx_c;
  logic [TAGW-1:0] tag_c;
  logic            hit_any_c;
  logic [WB-1:0]   hit_way_c;
  logic            have_inv_c;
  logic [WB-1:0]   victim_c;
  logic            last_c;
  logic            miss_start_c;

  assign off_c = (BLKWORDS > 1) ? OBW'(imemaddr >> 2) : '0;
  assign idx_c = IB'(imemaddr >> (2 + OB));
  assign tag_c = TAGW'(imemaddr >> (2 + OB + IB));

  // Tag compare across all ways of the addressed set
  always_comb begin
    hit_any_c = 1'b0;
    hit_way_c = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx_c][w] && (tag_q[idx_c][w] == tag_c)) begin
        hit_any_c = 1'b1;
        hit_way_c = WB'(w);
      end
    end
  end

  // Lowest invalid way wins; otherwise the set's round-robin pointer
  always_comb begin
    have_inv_c = 1'b0;
    victim_c   = ptr_q[fidx_q];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[fidx_q][w]) begin
        have_inv_c = 1'b1;
        victim_c   = WB'(w);
      end
    end
  end

  assign ihit         = (state_q == IDLE) && imemREN && !iflush && hit_any_c;
  assign imemload     = ihit ? data_q[idx_c][hit_way_c][off_c] : '0;
  assign miss_start_c = (state_q == IDLE) && imemREN && !iflush && !hit_any_c;
  assign last_c       = (cnt_q == OBW'(BLKWORDS - 1));
  assign iREN         = (state_q == FILL);
  assign iaddr        = iREN ? ((32'(ftag_q) << (2 + OB + IB)) |
                                (32'(fidx_q) << (2 + OB)) |
                                ((BLKWORDS > 1) ? (32'(cnt_q) << 2) : 32'd0))
                             : '0;

  // Control FSM plus valid/pointer state; flush overrides everything
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ftag_q  <= '0;
      fidx_q  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else if (iflush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else if (miss_start_c) begin
      state_q <= FILL;
      ftag_q  <= tag_c;
      fidx_q  <= idx_c;
      cnt_q   <= '0;
    end else if ((state_q == FILL) && !iwait) begin
      if (last_c) begin
        valid_q[fidx_q][victim_c] <= 1'b1;
        if ((WAYS > 1) && !have_inv_c) begin
          ptr_q[fidx_q] <= WB'(ptr_q[fidx_q] + WB'(1));
        end
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + OBW'(1);
      end
    end
  end

  // Data and tag arrays need no reset; the last word bypasses the fill buffer
  always_ff @(posedge CLK) begin
    if ((state_q == FILL) && !iwait && !iflush) begin
      fbuf_q[cnt_q] <= iload;
      if (last_c) begin
        tag_q[fidx_q][victim_c] <= ftag_q;
        for (int b = 0; b < BLKWORDS; b++) begin
          data_q[fidx_q][victim_c][b] <= (OBW'(b) == cnt_q) ? iload : fbuf_q[b];
        end
      end
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (ihit)         hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_start_c) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule
